// File: rtl/control_pkg.sv
// Shared definitions for the main control decoder: opcode encodings,
// ALU operation classes and the packed datapath control word.
package control_pkg;

   localparam int OPW = 4;

   localparam logic [OPW-1:0] OP_TYPEA = 4'b0000;
   localparam logic [OPW-1:0] OP_BLT   = 4'b0100;
   localparam logic [OPW-1:0] OP_BGT   = 4'b0101;
   localparam logic [OPW-1:0] OP_BEQ   = 4'b0110;
   localparam logic [OPW-1:0] OP_LW    = 4'b1000;
   localparam logic [OPW-1:0] OP_SW    = 4'b1011;
   localparam logic [OPW-1:0] OP_JMP   = 4'b1100;
   localparam logic [OPW-1:0] OP_HALT  = 4'b1111;

   // 11 is never produced by the decoder
   localparam logic [1:0] ALU_ADD   = 2'b00;
   localparam logic [1:0] ALU_CMP   = 2'b01;
   localparam logic [1:0] ALU_FUNCT = 2'b10;

   typedef struct packed {
      logic       branch;
      logic       jump;
      logic       regdst;
      logic       memtoreg;
      logic       memread;
      logic [1:0] aluop;
      logic       memwrite;
      logic       alusrc;
      logic       regwrite;
   } ctrl_t;

   typedef enum logic {
      ST_RUN    = 1'b0,
      ST_HALTED = 1'b1
   } state_t;

endpackage

// File: rtl/control_decode.sv
// Combinational opcode-to-control-word decoder. Undefined opcodes give an
// all-zero (NOP) control word with the illegal flag raised; HALT is a
// defined opcode that also yields an all-zero control word.
module control_decode
   import control_pkg::*;
#(
   parameter int OPW = 4
) (
   input  logic [OPW-1:0] opcode,
   output ctrl_t          cw,
   output logic           illegal
);

   // Opcode table lookup; every field defaults to 0
   always_comb begin
      cw      = '0;
      illegal = 1'b0;
      case (opcode)
         OP_TYPEA: begin
            cw.regdst   = 1'b1;
            cw.regwrite = 1'b1;
            cw.aluop    = ALU_FUNCT;
         end
         OP_LW: begin
            cw.alusrc   = 1'b1;
            cw.memtoreg = 1'b1;
            cw.memread  = 1'b1;
            cw.regwrite = 1'b1;
            cw.aluop    = ALU_ADD;
         end
         OP_SW: begin
            cw.alusrc   = 1'b1;
            cw.memwrite = 1'b1;
            cw.aluop    = ALU_ADD;
         end
         OP_BLT, OP_BGT, OP_BEQ: begin
            cw.branch = 1'b1;
            cw.aluop  = ALU_CMP;
         end
         OP_JMP: begin
            cw.jump = 1'b1;
         end
         OP_HALT: begin
            cw = '0;
         end
         default: begin
            illegal = 1'b1;
         end
      endcase
   end

endmodule

// File: rtl/control_unit.sv
// Main control unit: registers the decoded control word (one clock of
// latency) and tracks the RUN/HALTED state. HALTED is left only by reset.
// Build option CONTROL_ILLEGAL_HALT_EN: an undefined opcode in RUN also
// enters HALTED instead of acting as a one-cycle NOP.
module control_unit
   import control_pkg::*;
#(
   parameter int OPW = 4
) (
   input  logic           clk,
   input  logic           rst,
   input  logic [OPW-1:0] opcode,
   output logic           Branch,
   output logic           Jump,
   output logic           RegDst,
   output logic           MemtoReg,
   output logic           MemRead,
   output logic           ALUOp1,
   output logic           ALUOp0,
   output logic           MemWrite,
   output logic           ALUSrc,
   output logic           RegWrite,
   output logic           halted,
   output logic           illegal_op
);

   ctrl_t  dec_cw;
   logic   dec_illegal;
   ctrl_t  ctrl_q;
   logic   illegal_q;
   state_t state;

   control_decode #(.OPW(OPW)) u_dec (
      .opcode  (opcode),
      .cw      (dec_cw),
      .illegal (dec_illegal)
   );

   // State machine with registered control outputs; reset has priority
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_RUN;
         ctrl_q    <= '0;
         illegal_q <= 1'b0;
      end else begin
         case (state)
            ST_RUN: begin
               ctrl_q    <= dec_cw;
               illegal_q <= dec_illegal;
               if (opcode == OP_HALT)
                  state <= ST_HALTED;
`ifdef CONTROL_ILLEGAL_HALT_EN
               if (dec_illegal)
                  state <= ST_HALTED;
`endif
            end
            ST_HALTED: begin
               // opcode ignored until reset
               ctrl_q    <= '0;
               illegal_q <= 1'b0;
            end
            default: begin
               state     <= ST_RUN;
               ctrl_q    <= '0;
               illegal_q <= 1'b0;
            end
         endcase
      end
   end

   // Flatten the registered control word onto the named outputs
   always_comb begin
      Branch     = ctrl_q.branch;
      Jump       = ctrl_q.jump;
      RegDst     = ctrl_q.regdst;
      MemtoReg   = ctrl_q.memtoreg;
      MemRead    = ctrl_q.memread;
      ALUOp1     = ctrl_q.aluop[1];
      ALUOp0     = ctrl_q.aluop[0];
      MemWrite   = ctrl_q.memwrite;
      ALUSrc     = ctrl_q.alusrc;
      RegWrite   = ctrl_q.regwrite;
      halted     = (state == ST_HALTED);
      illegal_op = illegal_q;
   end

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit. Outputs are compared as one 12-bit word
// {Branch,Jump,RegDst,MemtoReg,MemRead,ALUOp1,ALUOp0,MemWrite,ALUSrc,
//  RegWrite,halted,illegal_op} against hand-computed constants, followed by
// a random run checking the exclusivity invariants every cycle.
module tb_control_unit;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] opcode;
   logic Branch, Jump, RegDst, MemtoReg, MemRead, ALUOp1, ALUOp0;
   logic MemWrite, ALUSrc, RegWrite, halted, illegal_op;

   int checks   = 0;
   int failures = 0;

   // B J RD MtR MR A1 A0 MW AS RW H I
   localparam logic [11:0] E_ZERO  = 12'b0000_0000_0000;
   localparam logic [11:0] E_TYPEA = 12'b0010_0100_0100;
   localparam logic [11:0] E_LW    = 12'b0001_1000_1100;
   localparam logic [11:0] E_SW    = 12'b0000_0001_1000;
   localparam logic [11:0] E_BR    = 12'b1000_0010_0000;
   localparam logic [11:0] E_JMP   = 12'b0100_0000_0000;
   localparam logic [11:0] E_HALT  = 12'b0000_0000_0010;
`ifdef CONTROL_ILLEGAL_HALT_EN
   localparam logic [11:0] E_ILL   = 12'b0000_0000_0011;
`else
   localparam logic [11:0] E_ILL   = 12'b0000_0000_0001;
`endif

   control_unit #(.OPW(4)) dut (
      .clk        (clk),
      .rst        (rst),
      .opcode     (opcode),
      .Branch     (Branch),
      .Jump       (Jump),
      .RegDst     (RegDst),
      .MemtoReg   (MemtoReg),
      .MemRead    (MemRead),
      .ALUOp1     (ALUOp1),
      .ALUOp0     (ALUOp0),
      .MemWrite   (MemWrite),
      .ALUSrc     (ALUSrc),
      .RegWrite   (RegWrite),
      .halted     (halted),
      .illegal_op (illegal_op)
   );

   always #5 clk = ~clk;

   function automatic logic [11:0] outw();
      return {Branch, Jump, RegDst, MemtoReg, MemRead, ALUOp1, ALUOp0,
              MemWrite, ALUSrc, RegWrite, halted, illegal_op};
   endfunction

   task automatic chk(input string tag, input logic [11:0] act, input logic [11:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %b expected %b", tag, act, exp);
      end
   endtask

   // drive on the falling edge, let one rising edge pass, sample on the next fall
   task automatic step(input logic r, input logic [3:0] op);
      rst    = r;
      opcode = op;
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      rst    = 1'b1;
      opcode = 4'b0000;
      @(negedge clk);

      // reset held two cycles
      step(1'b1, 4'b0000); chk("reset0", outw(), E_ZERO);
      step(1'b1, 4'b0000); chk("reset1", outw(), E_ZERO);
      step(1'b0, 4'b0000); chk("typea_after_reset", outw(), E_TYPEA);

      // decode table rows
      step(1'b0, 4'b1000); chk("lw", outw(), E_LW);
      step(1'b0, 4'b1011); chk("sw", outw(), E_SW);
      step(1'b0, 4'b0100); chk("blt", outw(), E_BR);
      step(1'b0, 4'b0101); chk("bgt", outw(), E_BR);
      step(1'b0, 4'b0110); chk("beq", outw(), E_BR);
      step(1'b0, 4'b1100); chk("jmp", outw(), E_JMP);
      step(1'b0, 4'b0000); chk("typea", outw(), E_TYPEA);

      // halt is sticky, opcode ignored
      step(1'b0, 4'b1111); chk("halt", outw(), E_HALT);
      step(1'b0, 4'b0000); chk("halted_typea", outw(), E_HALT);
      step(1'b0, 4'b1000); chk("halted_lw", outw(), E_HALT);
      step(1'b0, 4'b0011); chk("halted_undef", outw(), E_HALT);

      // reset with a halt opcode present: reset wins
      step(1'b1, 4'b1111); chk("reset_vs_halt", outw(), E_ZERO);
      step(1'b0, 4'b0000); chk("typea_after_unhalt", outw(), E_TYPEA);

      // undefined opcode
      step(1'b0, 4'b0011); chk("undef_0011", outw(), E_ILL);
`ifdef CONTROL_ILLEGAL_HALT_EN
      step(1'b0, 4'b1000); chk("ill_halt_lw", outw(), E_HALT);
      step(1'b0, 4'b0000); chk("ill_halt_typea", outw(), E_HALT);
      step(1'b1, 4'b0000); chk("reset2", outw(), E_ZERO);
`else
      step(1'b0, 4'b1000); chk("lw_after_undef", outw(), E_LW);
      step(1'b0, 4'b0111); chk("undef_0111", outw(), E_ILL);
      step(1'b0, 4'b1110); chk("undef_1110", outw(), E_ILL);
      step(1'b0, 4'b1011); chk("sw_after_undef", outw(), E_SW);
`endif

      // random opcodes: exclusivity invariants every cycle
      step(1'b1, 4'b0000);
      for (int i = 0; i < 200; i++) begin
         step(1'b0, 4'($urandom_range(0, 15)));
         chk("inv_mem", {11'b0, MemRead & MemWrite}, 12'b0);
         chk("inv_brj", {11'b0, Branch & Jump}, 12'b0);
         chk("inv_alu", {11'b0, ALUOp1 & ALUOp0}, 12'b0);
         if (halted) step(1'b1, 4'b0000);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
